// File: rtl/vc_pop_arbiter_pkg.sv
// rtl/vc_pop_arbiter_pkg.sv - state encodings and index constants for the VC pop arbiter
package vc_pop_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    localparam int VC0 = 0;
    localparam int VC1 = 1;

    function automatic int dest_bit(input int data_width);
        return data_width - 2;
    endfunction

endpackage

// File: rtl/vc_arb_grant.sv
// rtl/vc_arb_grant.sv - VC eligibility and single-grant selection (round robin under ARB_RR_EN)
module vc_arb_grant
    import vc_pop_arbiter_pkg::*;
(
`ifdef ARB_RR_EN
    input  logic       last_grant_i,
`endif
    input  logic       run_i,
    input  logic [1:0] empty_i,
    input  logic [1:0] head_dest_i,
    input  logic [1:0] almost_full_i,
    input  logic [1:0] prev_pop_i,
    output logic [1:0] rd_en_o,
    output logic       any_elig_o
);

    logic [1:0] elig;

    always_comb begin
        elig[VC0] = run_i && !empty_i[VC0] && !almost_full_i[head_dest_i[VC0]] && !prev_pop_i[VC0];
        elig[VC1] = run_i && !empty_i[VC1] && !almost_full_i[head_dest_i[VC1]] && !prev_pop_i[VC1];
    end

    always_comb begin
        rd_en_o = '0;
        if (elig[VC0] && elig[VC1]) begin
`ifdef ARB_RR_EN
            // last_grant_i: 0 = VC0 was granted last, 1 = VC1
            if (last_grant_i) rd_en_o[VC0] = 1'b1;
            else              rd_en_o[VC1] = 1'b1;
`else
            rd_en_o[VC0] = 1'b1;
`endif
        end else begin
            rd_en_o = elig;
        end
    end

    assign any_elig_o = |elig;

endmodule

// File: rtl/vc_pop_arbiter.sv
// rtl/vc_pop_arbiter.sv - pops VC0/VC1 heads and routes words to D0/D1; ARB_RR_EN selects round-robin ties
module vc_pop_arbiter
    import vc_pop_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH-1:0] umbral_vc_in,
    input  logic [ADDR_WIDTH-1:0] umbral_d_in,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc0_head,
    input  logic [DATA_WIDTH-1:0] vc1_head,
    input  logic [DATA_WIDTH-1:0] vc0_data_out,
    input  logic [DATA_WIDTH-1:0] vc1_data_out,
    input  logic                  d0_almost_full,
    input  logic                  d1_almost_full,
    output logic                  vc0_rd_en,
    output logic                  vc1_rd_en,
    output logic                  d0_push,
    output logic                  d1_push,
    output logic [DATA_WIDTH-1:0] d0_data,
    output logic [DATA_WIDTH-1:0] d1_data,
    output logic [ADDR_WIDTH-1:0] umbral_vc_out,
    output logic [ADDR_WIDTH-1:0] umbral_d_out,
    output logic [1:0]            state,
    output logic                  idle
);

    localparam int DEST_BIT = dest_bit(DATA_WIDTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] umbral_vc_q, umbral_d_q;
    logic                  pend_valid_q, pend_src_q, pend_dst_q;
    logic                  run, any_elig;
    logic [1:0]            rd_en, prev_pop;
    logic                  unused_head_bits;

    assign unused_head_bits = ^{vc0_head, vc1_head};

    assign run      = reset && init && (state_q == ST_IDLE || state_q == ST_ACTIVE);
    assign prev_pop = {pend_valid_q && pend_src_q, pend_valid_q && !pend_src_q};

`ifdef ARB_RR_EN
    logic last_grant_q;

    always_ff @(posedge clk) begin
        if (!reset)      last_grant_q <= 1'b1;
        else if (|rd_en) last_grant_q <= rd_en[VC1];
    end
`endif

    vc_arb_grant u_grant (
`ifdef ARB_RR_EN
        .last_grant_i  (last_grant_q),
`endif
        .run_i         (run),
        .empty_i       ({vc1_empty, vc0_empty}),
        .head_dest_i   ({vc1_head[DEST_BIT], vc0_head[DEST_BIT]}),
        .almost_full_i ({d1_almost_full, d0_almost_full}),
        .prev_pop_i    (prev_pop),
        .rd_en_o       (rd_en),
        .any_elig_o    (any_elig)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (init) state_d = ST_IDLE;
            ST_IDLE:   if (!init) state_d = ST_INIT;
                       else if (any_elig) state_d = ST_ACTIVE;
            ST_ACTIVE: if (!init) state_d = ST_INIT;
                       else if (!any_elig && !pend_valid_q) state_d = ST_IDLE;
            default:   state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_RESET;
            umbral_vc_q  <= '0;
            umbral_d_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_src_q   <= 1'b0;
            pend_dst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                umbral_vc_q <= umbral_vc_in;
                umbral_d_q  <= umbral_d_in;
            end
            // rd_en is already zero outside IDLE/ACTIVE, so this also clears pending on leaving run
            pend_valid_q <= |rd_en;
            if (|rd_en) begin
                pend_src_q <= rd_en[VC1];
                pend_dst_q <= rd_en[VC1] ? vc1_head[DEST_BIT] : vc0_head[DEST_BIT];
            end
        end
    end

    always_comb begin
        d0_push = 1'b0;
        d1_push = 1'b0;
        d0_data = '0;
        d1_data = '0;
        if (run && pend_valid_q) begin
            if (pend_dst_q) begin
                d1_push = 1'b1;
                d1_data = pend_src_q ? vc1_data_out : vc0_data_out;
            end else begin
                d0_push = 1'b1;
                d0_data = pend_src_q ? vc1_data_out : vc0_data_out;
            end
        end
    end

    assign vc0_rd_en     = rd_en[VC0];
    assign vc1_rd_en     = rd_en[VC1];
    assign umbral_vc_out = umbral_vc_q;
    assign umbral_d_out  = umbral_d_q;
    assign state         = state_q;
    assign idle          = (state_q == ST_IDLE);

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// tb/tb_vc_pop_arbiter.sv - directed plus randomized bench for vc_pop_arbiter against a transaction model
module tb_vc_pop_arbiter;

    logic       clk = 1'b0;
    logic       reset, init;
    logic [3:0] umbral_vc_in, umbral_d_in;
    logic       vc0_empty, vc1_empty;
    logic [5:0] vc0_head, vc1_head, vc0_data_out, vc1_data_out;
    logic       d0_almost_full, d1_almost_full;
    logic       vc0_rd_en, vc1_rd_en, d0_push, d1_push;
    logic [5:0] d0_data, d1_data;
    logic [3:0] umbral_vc_out, umbral_d_out;
    logic [1:0] state;
    logic       idle;

    always #5 clk = ~clk;

    vc_pop_arbiter dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_vc_in(umbral_vc_in), .umbral_d_in(umbral_d_in),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_head(vc0_head), .vc1_head(vc1_head),
        .vc0_data_out(vc0_data_out), .vc1_data_out(vc1_data_out),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .vc0_rd_en(vc0_rd_en), .vc1_rd_en(vc1_rd_en),
        .d0_push(d0_push), .d1_push(d1_push),
        .d0_data(d0_data), .d1_data(d1_data),
        .umbral_vc_out(umbral_vc_out), .umbral_d_out(umbral_d_out),
        .state(state), .idle(idle)
    );

    // VC FIFO contents as seen by the arbiter
    logic [5:0] vq0[$];
    logic [5:0] vq1[$];

    // Reference model: spec-level state
    int         m_state, m_last_pop, m_last_grant;
    bit         m_pend, m_pend_dst;
    logic [5:0] m_pend_word;
    logic [3:0] m_thr_vc, m_thr_d;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] q_head(input int n);
        if (n == 0) return (vq0.size() > 0) ? vq0[0] : 6'h0;
        return (vq1.size() > 0) ? vq1[0] : 6'h0;
    endfunction

    function automatic int q_size(input int n);
        return (n == 0) ? vq0.size() : vq1.size();
    endfunction

    task automatic refresh();
        vc0_empty = (vq0.size() == 0);
        vc1_empty = (vq1.size() == 0);
        vc0_head  = (vq0.size() > 0) ? vq0[0] : 6'($urandom);
        vc1_head  = (vq1.size() > 0) ? vq1[0] : 6'($urandom);
    endtask

    task automatic tick();
        bit         run;
        bit   [1:0] el, exp_push, s_rd;
        logic [1:0] exp_rd, af;
        logic [5:0] hd, exp_d0, exp_d1;
        int         g, nxt;
        refresh();
        @(negedge clk);
        af  = {d1_almost_full, d0_almost_full};
        run = reset && init && (m_state >= 2);
        for (int n = 0; n < 2; n++) begin
            hd    = q_head(n);
            el[n] = run && q_size(n) > 0 && !af[hd[4]] && m_last_pop != n;
        end
        g = -1;
        if (el == 2'b11) begin
`ifdef ARB_RR_EN
            g = (m_last_grant == 0) ? 1 : 0;
`else
            g = 0;
`endif
        end else if (el[0]) g = 0;
        else if (el[1]) g = 1;
        exp_rd   = (g < 0) ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
        exp_push = (run && m_pend) ? (m_pend_dst ? 2'b10 : 2'b01) : 2'b00;
        exp_d0   = exp_push[0] ? m_pend_word : 6'h0;
        exp_d1   = exp_push[1] ? m_pend_word : 6'h0;
        check_eq("rd_en", {vc1_rd_en, vc0_rd_en}, exp_rd);
        check_eq("push", {d1_push, d0_push}, exp_push);
        check_eq("d0_data", d0_data, exp_d0);
        check_eq("d1_data", d1_data, exp_d1);
        check_eq("state", state, m_state);
        check_eq("idle", idle, m_state == 2);
        check_eq("umbral_vc", umbral_vc_out, m_thr_vc);
        check_eq("umbral_d", umbral_d_out, m_thr_d);
        s_rd = {vc1_rd_en, vc0_rd_en};

        if (!reset) begin
            m_state = 0; m_pend = 0; m_last_pop = -1; m_last_grant = 1;
            m_thr_vc = 0; m_thr_d = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_pend = 0; m_last_pop = -1;
        end else if (m_state == 1) begin
            m_thr_vc = umbral_vc_in; m_thr_d = umbral_d_in;
            m_pend = 0; m_last_pop = -1;
            if (init) m_state = 2;
        end else if (!init) begin
            m_state = 1; m_pend = 0; m_last_pop = -1;
        end else begin
            nxt = m_state;
            if (m_state == 2 && el != 0) nxt = 3;
            if (m_state == 3 && el == 0 && !m_pend) nxt = 2;
            m_state    = nxt;
            m_pend     = (g >= 0);
            m_last_pop = g;
            if (g >= 0) begin
                m_pend_word  = q_head(g);
                m_pend_dst   = m_pend_word[4];
                m_last_grant = g;
            end
        end

        @(posedge clk);
        #1;
        if (s_rd[0] && vq0.size() > 0) vc0_data_out = vq0.pop_front();
        if (s_rd[1] && vq1.size() > 0) vc1_data_out = vq1.pop_front();
    endtask

    initial begin
        reset = 0; init = 0; umbral_vc_in = 0; umbral_d_in = 0;
        d0_almost_full = 0; d1_almost_full = 0;
        vc0_data_out = 0; vc1_data_out = 0;
        m_state = 0; m_pend = 0; m_pend_dst = 0; m_pend_word = 0;
        m_last_pop = -1; m_last_grant = 1; m_thr_vc = 0; m_thr_d = 0;
        refresh();
        @(posedge clk);
        #1;

        // reset held, then programming
        repeat (3) tick();
        reset = 1; umbral_vc_in = 4'd3; umbral_d_in = 4'd2;
        repeat (3) tick();
        check_eq("thr_vc_prog", umbral_vc_out, 4'd3);
        check_eq("thr_d_prog", umbral_d_out, 4'd2);

        // single VC, two words to different destinations
        vq0.push_back(6'h05); vq0.push_back(6'h15);
        init = 1;
        repeat (8) tick();

        // both VCs loaded, all destined to D0
        for (int i = 0; i < 4; i++) begin
            vq0.push_back(6'($urandom) & 6'h2F);
            vq1.push_back(6'($urandom) & 6'h2F);
        end
        repeat (10) tick();

        // VC0 blocked by D1 almost-full while VC1 drains to D0
        vq0.push_back(6'h12);
        vq1.push_back(6'h03); vq1.push_back(6'h07);
        d1_almost_full = 1;
        repeat (5) tick();
        d1_almost_full = 0;
        repeat (4) tick();

        // init dropped right after a pop
        vq0.push_back(6'h21); vq0.push_back(6'h22);
        for (int i = 0; i < 10 && !m_pend; i++) tick();
        check_eq("pend_before_drop", m_pend, 1'b1);
        init = 0;
        repeat (3) tick();
        init = 1;
        repeat (6) tick();

        // randomized traffic with occasional reset/init drops
        for (int c = 0; c < 800; c++) begin
            reset          = ($urandom % 80) != 0;
            init           = ($urandom % 20) != 0;
            d0_almost_full = ($urandom % 4) == 0;
            d1_almost_full = ($urandom % 4) == 0;
            umbral_vc_in   = 4'($urandom);
            umbral_d_in    = 4'($urandom);
            if (($urandom % 2) && vq0.size() < 8) vq0.push_back(6'($urandom));
            if (($urandom % 2) && vq1.size() < 8) vq1.push_back(6'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
